// File: rtl/high_score_text_renderer.sv
// "HIGH SCORE" banner reader: drives the glyph ROM address from the pixel coordinates, covers the
// ROM's one-clock latency with a two-stage pipeline and gates the mask with a frame-counted blink.
module high_score_text_renderer #(
  parameter int unsigned X0            = 256,
  parameter int unsigned Y0            = 208,
  parameter int unsigned SCALE_LOG2    = 1,
  parameter int unsigned BLINK_FRAMES  = 15,
  parameter int unsigned BLINK_TOGGLES = 8,
  parameter logic [11:0] TEXT_RGB      = 12'hFF0,
  parameter logic [11:0] BG_RGB        = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic        new_high,
  input  logic [7:0]  rom_data,
  output logic [10:0] rom_addr,
  output logic        text_on,
  output logic [11:0] rgb,
  output logic        video_on_out
);

  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned TW = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;
  localparam logic [FW-1:0] FrameLast  = FW'(BLINK_FRAMES - 1);
  localparam logic [TW-1:0] ToggleLast = TW'(BLINK_TOGGLES - 1);
  localparam logic [9:0]    X0V        = 10'(X0);
  localparam logic [9:0]    Y0V        = 10'(Y0);

  typedef enum logic [1:0] {StIdle, StShow, StHide} state_e;

  // ---------------------------------------------------------------------------
  // Address generation (combinational)
  // ---------------------------------------------------------------------------
  logic [9:0] rel_x, rel_y, xs, ys;
  logic [3:0] col;
  logic [2:0] bit_idx;
  logic [3:0] row;
  logic [6:0] slot;
  logic       in_region;

  always_comb begin
    rel_x   = x - X0V;
    rel_y   = y - Y0V;
    // Comparing the de-magnified coordinates is the same as rel < 80<<S and rel < 16<<S.
    xs      = rel_x >> SCALE_LOG2;
    ys      = rel_y >> SCALE_LOG2;
    in_region = (xs < 10'd80) && (ys < 10'd16);
    col     = xs[6:3];
    bit_idx = xs[2:0];
    row     = ys[3:0];
  end

  always_comb begin
    slot = 7'd0;
    case (col)
      4'd0:    slot = 7'd3;
      4'd1:    slot = 7'd4;
      4'd2:    slot = 7'd5;
      4'd3:    slot = 7'd6;
      4'd4:    slot = 7'd0;
      4'd5:    slot = 7'd7;
      4'd6:    slot = 7'd8;
      4'd7:    slot = 7'd9;
      4'd8:    slot = 7'd10;
      4'd9:    slot = 7'd11;
      default: slot = 7'd0;
    endcase
  end

  assign rom_addr = in_region ? {slot, row} : 11'h000;

  // ---------------------------------------------------------------------------
  // Blink FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [TW-1:0]   toggle_cnt_q, toggle_cnt_d;
  logic            visible;

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    toggle_cnt_d = toggle_cnt_q;
    if (new_high) begin
      // A coincident frame_tick is dropped so the restart always gets a full SHOW period.
      state_d      = StShow;
      frame_cnt_d  = '0;
      toggle_cnt_d = '0;
    end else if (frame_tick && (state_q != StIdle)) begin
      if (frame_cnt_q == FrameLast) begin
        frame_cnt_d = '0;
        if (toggle_cnt_q == ToggleLast) begin
          state_d      = StIdle;
          toggle_cnt_d = '0;
        end else begin
          toggle_cnt_d = toggle_cnt_q + 1'b1;
          state_d      = (state_q == StShow) ? StHide : StShow;
        end
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Next state so a transition applies to the pixel captured on the same edge.
  assign visible = (state_d != StHide);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      frame_cnt_q  <= '0;
      toggle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline: stage 1 runs alongside the ROM, stage 2 merges rom_data
  // ---------------------------------------------------------------------------
  logic        in_region_q, in_region_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        video_on_q, video_on_d;
  logic        text_on_q, text_on_d;
  logic [11:0] rgb_q, rgb_d;
  logic        video_on_out_q, video_on_out_d;

  always_comb begin
    in_region_d    = in_region;
    bit_idx_d      = bit_idx;
    video_on_d     = video_on;
    text_on_d      = in_region_q & rom_data[3'd7 - bit_idx_q] & visible;
    rgb_d          = video_on_q ? (text_on_d ? TEXT_RGB : BG_RGB) : 12'h000;
    video_on_out_d = video_on_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_region_q    <= 1'b0;
      bit_idx_q      <= 3'd0;
      video_on_q     <= 1'b0;
      text_on_q      <= 1'b0;
      rgb_q          <= 12'h000;
      video_on_out_q <= 1'b0;
    end else begin
      in_region_q    <= in_region_d;
      bit_idx_q      <= bit_idx_d;
      video_on_q     <= video_on_d;
      text_on_q      <= text_on_d;
      rgb_q          <= rgb_d;
      video_on_out_q <= video_on_out_d;
    end
  end

  assign text_on      = text_on_q;
  assign rgb          = rgb_q;
  assign video_on_out = video_on_out_q;

endmodule
